// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a registered borrow.
// Handles one bit per clock, LSB first, and uses a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_difference,
  output logic             o_borrow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    count;
  logic             bin;
  logic             a_bit, b_bit, d, bout, last, accept;
  logic [WIDTH:0]   res_ext;

  always_comb begin
    a_bit   = a_sh[0];
    b_bit   = b_sh[0];
    d       = a_bit ^ b_bit ^ bin;
    bout    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
    last    = (count == CW'(WIDTH - 1));
    accept  = i_start && (state != RUN);
    // The new bit enters at the MSB; the extra bit keeps this legal when WIDTH is 1.
    res_ext = {d, res};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last)    state_next = DONE;
      DONE:    state_next = i_start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res          <= '0;
      bin          <= 1'b0;
      count        <= '0;
      o_difference <= '0;
      o_borrow     <= 1'b0;
    end else if (accept) begin
      a_sh  <= i_minuend;
      b_sh  <= i_subtrahend;
      res   <= '0;
      bin   <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res   <= res_ext[WIDTH:1];
      bin   <= bout;
      count <= count + CW'(1);
      if (last) begin
        o_difference <= res_ext[WIDTH:1];
        o_borrow     <= bout;
      end
    end
  end

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8, 1 and 13.
// Expected results come from plain (a-b) mod 2^W arithmetic plus a done-cycle latency model.
module tb_serial_subtractor;

  typedef struct {
    logic [12:0] diff;
    logic        borrow;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic [12:0] a_in  [3];
  logic [12:0] b_in  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        borrow[3];
  logic [12:0] diff  [3];
  logic [7:0]  diff8;
  logic [0:0]  diff1;
  logic [12:0] diff13;

  exp_t        sb [3][$];
  int unsigned done_cnt [3];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_start(start[0]),
    .i_minuend(a_in[0][7:0]), .i_subtrahend(b_in[0][7:0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_difference(diff8), .o_borrow(borrow[0])
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start[1]),
    .i_minuend(a_in[1][0:0]), .i_subtrahend(b_in[1][0:0]),
    .o_busy(busy[1]), .o_done(done[1]), .o_difference(diff1), .o_borrow(borrow[1])
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .i_clock(clk), .i_reset(rst), .i_start(start[2]),
    .i_minuend(a_in[2]), .i_subtrahend(b_in[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_difference(diff13), .o_borrow(borrow[2])
  );

  assign diff[0] = {5'b0, diff8};
  assign diff[1] = {12'b0, diff1};
  assign diff[2] = diff13;

  function automatic int unsigned width(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 13;
    endcase
  endfunction

  function automatic logic [12:0] mask(input int k);
    int unsigned m;
    m = (32'd1 << width(k)) - 1;
    return m[12:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (done[k]) begin
          exp_t e;
          done_cnt[k]++;
          if (sb[k].size() == 0) begin
            fail_now($sformatf("spurious_done inst%0d cyc=%0d", k, cyc));
          end else begin
            e = sb[k].pop_front();
            check($sformatf("diff inst%0d", k), {19'b0, diff[k]}, {19'b0, e.diff});
            check($sformatf("borrow inst%0d", k), {31'b0, borrow[k]}, {31'b0, e.borrow});
            check($sformatf("latency inst%0d", k), cyc, e.cyc);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge where the instance can accept a start.
  task automatic wait_ready(input int k);
    int n = 0;
    while (busy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy[k]) fail_now($sformatf("ready_timeout inst%0d", k));
  endtask

  task automatic push_exp(input int k, input logic [12:0] a, input logic [12:0] b);
    exp_t e;
    logic [12:0] am, bm;
    am = a & mask(k);
    bm = b & mask(k);
    e.diff   = (am - bm) & mask(k);
    e.borrow = (am < bm);
    e.cyc    = cyc + 1 + width(k);
    sb[k].push_back(e);
  endtask

  task automatic issue(input int k, input logic [12:0] a, input logic [12:0] b);
    wait_ready(k);
    start[k] = 1'b1;
    a_in[k]  = a;
    b_in[k]  = b;
    push_exp(k, a, b);
    @(negedge clk);
    start[k] = 1'b0;
    a_in[k]  = 13'($urandom);
    b_in[k]  = 13'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (sb[k].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb[k].size() != 0) begin
      fail_now($sformatf("done_timeout inst%0d", k));
      sb[k].delete();
    end
    @(negedge clk);
  endtask

  task automatic sweep(input int k, input int jobs);
    logic [12:0] a, b;
    for (int j = 0; j < jobs; j++) begin
      a = 13'($urandom);
      b = 13'($urandom);
      case ($urandom_range(0, 5))
        0: b = a;
        1: begin a = '0; b = 13'd1; end
        2: begin a = '0; b = mask(k); end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(k, a, b);
    end
    wait_idle(k);
  endtask

  initial begin
    int unsigned first_done, cnt_before;
    int n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      a_in[k]  = '0;
      b_in[k]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy inst%0d", k), {31'b0, busy[k]}, 32'd0);
      check($sformatf("rst_done inst%0d", k), {31'b0, done[k]}, 32'd0);
      check($sformatf("rst_diff inst%0d", k), {19'b0, diff[k]}, 32'd0);
      check($sformatf("rst_borrow inst%0d", k), {31'b0, borrow[k]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 jobs.
    issue(0, 13'd100, 13'd37);  wait_idle(0);
    issue(0, 13'd5, 13'd9);     wait_idle(0);
    issue(0, 13'd0, 13'd1);     wait_idle(0);
    issue(0, 13'd0, 13'd0);     wait_idle(0);
    issue(0, 13'd255, 13'd255); wait_idle(0);

    // A start pulsed mid-job is ignored.
    cnt_before = done_cnt[0];
    issue(0, 13'd50, 13'd20);
    @(negedge clk);
    start[0] = 1'b1; a_in[0] = 13'd200; b_in[0] = 13'd1;
    @(negedge clk);
    start[0] = 1'b0; a_in[0] = 13'd7; b_in[0] = 13'd99;
    wait_idle(0);
    repeat (10) @(negedge clk);
    check("ignored_start_done_count", done_cnt[0] - cnt_before, 32'd1);

    // Reset mid-job clears everything, including the previous result.
    issue(0, 13'd77, 13'd33);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy[0]}, 32'd0);
    check("midrst_done", {31'b0, done[0]}, 32'd0);
    check("midrst_diff", {19'b0, diff[0]}, 32'd0);
    check("midrst_borrow", {31'b0, borrow[0]}, 32'd0);
    sb[0].delete();
    @(negedge clk);
    rst = 1'b0;
    cnt_before = done_cnt[0];
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt[0] - cnt_before, 32'd0);
    issue(0, 13'd90, 13'd91);
    wait_idle(0);

    // Start held from mid-job through DONE gives a back-to-back job.
    issue(0, 13'd40, 13'd12);
    start[0] = 1'b1; a_in[0] = 13'd9; b_in[0] = 13'd9;
    n = 0;
    while (!done[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done[0]) fail_now("b2b_first_done_timeout");
    first_done = cyc;
    push_exp(0, 13'd9, 13'd9);
    @(negedge clk);
    start[0] = 1'b0;
    check("b2b_second_due", sb[0][sb[0].size()-1].cyc, first_done + 9);
    wait_idle(0);

    fork
      sweep(0, 40);
      sweep(1, 150);
      sweep(2, 60);
    join

    for (int k = 0; k < 3; k++)
      check($sformatf("outstanding inst%0d", k), sb[k].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
